lfsr_gen: RTL and testbench

Parametrised Galois LFSR pseudo-random generator: the successor to the fixed 26-bit, 4-bit-seed LFSR. Width and feedback polynomial are parameters, the full state can be loaded, and an all-zero seed is replaced automatically so the generator cannot lock up. The serial output bit is packed into W-bit words and delivered on a valid/ready stream, so downstream consumers can stall the generator without losing sequence position.

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr_gen_if.sv | 26 ++
 rtl/lfsr_packer.sv | 85 ++++++++
 rtl/lfsr_gen.sv | 71 +++++++
 tb/tb_lfsr_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants, step function and stream FSM encoding for
//                the parametrised Galois LFSR generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Galois tap masks (x^0..x^(N-1) coefficients) for common widths.
  localparam logic [31:0] c_TAPS_4  = 32'h0000_0003;  // x^4+x+1
  localparam logic [31:0] c_TAPS_8  = 32'h0000_0071;  // x^8+x^6+x^5+x^4+1
  localparam logic [31:0] c_TAPS_16 = 32'h0000_6801;  // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] c_TAPS_26 = 32'h0000_0047;  // x^26+x^6+x^2+x+1
  localparam logic [31:0] c_TAPS_32 = 32'h0040_0007;  // x^32+x^22+x^2+x+1

  // Word packer occupancy: FULL means a complete word is being offered.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_e;

  // One Galois step for an n-bit register (n <= 32). The MSB is fed back to
  // bit 0 and XORed into every tapped position; taps[0] is always 1, so the
  // XOR of the whole mask also supplies next[0] = fb.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int          n);
    logic fb;
    fb = state[5'(n - 1)];
    return (state << 1) ^ (fb ? taps : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen_if
//  Description : Valid/ready word stream carrying packed LFSR output bits.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_gen_if #(
  parameter int W = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;

  modport master (
    output out_valid,
    output out_word,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_packer.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_packer
//  Description : Serial-to-W-bit packer with a registered valid/ready output.
//                First bit shifted in ends up in the MSB of the word.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_packer
  import lfsr_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         r,
  input  wire logic         bit_in,
  input  wire logic         bit_en,
  input  wire logic         clear,
  output logic              stall,
  output logic              out_valid,
  input  wire logic         out_ready,
  output logic [W-1:0]      out_word
);

  localparam int c_CW = $clog2(W + 1);

  pack_state_e     r_fsm;
  pack_state_e     w_fsm_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [W-1:0]    r_pack;
  logic [W-1:0]    r_word;
  logic [W-1:0]    w_pack_shift;
  logic            w_complete;

  // Shift works for W=1 too: the old single bit is pushed out entirely.
  assign w_pack_shift = (r_pack << 1) | W'(bit_in);
  assign w_complete   = bit_en & (r_cnt == c_CW'(W - 1));

  // Both outputs come straight from flops; out_ready only reaches stall.
  assign out_valid = (r_fsm == FULL);
  assign out_word  = r_word;
  assign stall     = out_valid & ~out_ready;

  // Stream occupancy register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) r_fsm <= FILL;
    else    r_fsm <= w_fsm_nxt;
  end

  // Next occupancy: load discards, completion refills, handshake empties.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      FILL: if (!clear && w_complete) w_fsm_nxt = FULL;
      FULL: begin
        if (clear)           w_fsm_nxt = FILL;
        else if (w_complete) w_fsm_nxt = FULL;
        else if (out_ready)  w_fsm_nxt = FILL;
      end
      default: w_fsm_nxt = FILL;
    endcase
  end

  // Bit counter, pack register and output word.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_cnt  <= '0;
      r_pack <= '0;
      r_word <= '0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (bit_en) begin
      if (w_complete) begin
        r_cnt  <= '0;
        r_pack <= '0;
        r_word <= w_pack_shift;
      end else begin
        r_cnt  <= r_cnt + c_CW'(1);
        r_pack <= w_pack_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised Galois LFSR (N <= 32) with loadable state,
//                zero-seed replacement and a W-bit valid/ready word output.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int           N            = 26,
  parameter logic [N-1:0] TAPS         = N'(c_TAPS_26),
  parameter logic [N-1:0] DEFAULT_SEED = N'(1),
  parameter int           W            = 8
) (
  input  wire logic         clk,
  input  wire logic         r,
  input  wire logic         en,
  input  wire logic         load,
  input  wire logic [N-1:0] seed,
  output logic [N-1:0]      state,
  output logic              zero_fix,
  lfsr_gen_if.master        out_if
);

  logic [N-1:0] r_state;
  logic         r_zero_fix;
  logic         w_stall;
  logic         w_advance;
  logic         w_seed_zero;
  logic [N-1:0] w_load_val;
  logic [N-1:0] w_step;

  assign w_seed_zero = (seed == '0);
  assign w_load_val  = w_seed_zero ? DEFAULT_SEED : seed;
  assign w_step      = N'(lfsr_next(32'(r_state), 32'(TAPS), N));
  // Load wins over advance; a stalled word freezes the whole generator.
  assign w_advance   = en & ~w_stall & ~load;

  assign state    = r_state;
  assign zero_fix = r_zero_fix;

  // LFSR state: load (with zero replacement) or one Galois step.
  always_ff @(posedge clk or negedge r) begin
    if (!r)             r_state <= DEFAULT_SEED;
    else if (load)      r_state <= w_load_val;
    else if (w_advance) r_state <= w_step;
  end

  // One-cycle flag marking that a zero seed was substituted.
  always_ff @(posedge clk or negedge r) begin
    if (!r) r_zero_fix <= 1'b0;
    else    r_zero_fix <= load & w_seed_zero;
  end

  lfsr_packer #(
    .W (W)
  ) u_packer (
    .clk       (clk),
    .r         (r),
    .bit_in    (r_state[N-1]),
    .bit_en    (w_advance),
    .clear     (load),
    .stall     (w_stall),
    .out_valid (out_if.out_valid),
    .out_ready (out_if.out_ready),
    .out_word  (out_if.out_word)
  );

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Self-checking bench for lfsr_gen against a bit-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lfsr_gen;
  localparam int           N        = 26;
  localparam int           W        = 8;
  localparam logic [N-1:0] TAPS_REF = 26'h0000047;

  logic clk = 1'b0;
  logic r   = 1'b0;
  always #5 clk = ~clk;

  logic         en = 1'b0, load = 1'b0, ready = 1'b1;
  logic [N-1:0] seed = '0;
  logic [N-1:0] state;
  logic         zero_fix;
  lfsr_gen_if #(.W(W)) bus ();
  assign bus.out_ready = ready;

  lfsr_gen #(.N(N), .TAPS(26'h0000047), .DEFAULT_SEED(26'h1), .W(W)) dut (
    .clk(clk), .r(r), .en(en), .load(load), .seed(seed),
    .state(state), .zero_fix(zero_fix), .out_if(bus.master));

  logic       en4 = 1'b0, load4 = 1'b0;
  logic [3:0] seed4 = 4'h0;
  logic [3:0] state4;
  logic       zf4;
  lfsr_gen_if #(.W(4)) bus4 ();
  assign bus4.out_ready = 1'b1;

  lfsr_gen #(.N(4), .TAPS(4'h3), .DEFAULT_SEED(4'h1), .W(4)) dut4 (
    .clk(clk), .r(r), .en(en4), .load(load4), .seed(seed4),
    .state(state4), .zero_fix(zf4), .out_if(bus4.master));

  // Reference model: emitted bits queued until W are collected.
  logic [N-1:0] m_state;
  bit           m_bits[$];
  logic         m_valid;
  logic [W-1:0] m_word;
  logic         m_zf;
  logic [W-1:0] got_words[$];
  logic [W-1:0] exp_words[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [N-1:0] ref_next(input logic [N-1:0] s);
    logic [N-1:0] nx;
    logic         fb;
    fb    = s[N-1];
    nx[0] = fb;
    for (int i = 1; i < N; i++) nx[i] = s[i-1] ^ (fb & TAPS_REF[i]);
    return nx;
  endfunction

  task automatic model_reset();
    m_state = 26'h1;
    m_bits.delete();
    m_valid = 1'b0;
    m_word  = '0;
    m_zf    = 1'b0;
    got_words.delete();
    exp_words.delete();
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model for the
  // coming rising edge, and return at the next falling edge.
  task automatic tick(input logic e, input logic l, input logic [N-1:0] s, input logic rd);
    logic         hs, adv, newword;
    logic [W-1:0] wv;
    en = e; load = l; seed = s; ready = rd;
    #1;
    if (bus.out_valid && rd) got_words.push_back(bus.out_word);
    if (m_valid && rd) exp_words.push_back(m_word);
    hs      = m_valid & rd;
    adv     = e & ~(m_valid & ~rd) & ~l;
    newword = 1'b0;
    m_zf    = l && (s == '0);
    if (l) begin
      m_state = (s == '0) ? 26'h1 : s;
      m_bits.delete();
    end else if (adv) begin
      m_bits.push_back(m_state[N-1]);
      m_state = ref_next(m_state);
      if (m_bits.size() == W) begin
        wv = '0;
        foreach (m_bits[i]) wv[W-1-i] = m_bits[i];
        m_word = wv;
        m_bits.delete();
        newword = 1'b1;
      end
    end
    if (l)            m_valid = 1'b0;
    else if (newword) m_valid = 1'b1;
    else if (hs)      m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    r = 1'b0; en = 0; load = 0; seed = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (state !== 26'h1) begin n_fail++; $display("FAIL reset_state: got %h expected %h", state, 26'h1); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_word !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h expected 00", bus.out_word); end
    n_tests++; if (zero_fix !== 1'b0) begin n_fail++; $display("FAIL reset_zero_fix: got %b expected 0", zero_fix); end
    r = 1'b1;
    @(negedge clk);
    model_reset();
    n_tests++; if (state !== 26'h1) begin n_fail++; $display("FAIL reset_release_state: got %h expected %h", state, 26'h1); end
  endtask

  task automatic test_step();
    for (int c = 1; c <= 26; c++) begin
      tick(1'b1, 1'b0, '0, 1'b1);
      if (c == 1) begin
        n_tests++; if (state !== 26'h0000002) begin n_fail++; $display("FAIL step_1: got %h expected 0000002", state); end
      end
      if (c == 25) begin
        n_tests++; if (state !== 26'h2000000) begin n_fail++; $display("FAIL step_25: got %h expected 2000000", state); end
      end
      if (c == 26) begin
        n_tests++; if (state !== 26'h0000047) begin n_fail++; $display("FAIL step_26: got %h expected 0000047", state); end
      end
      n_tests++; if (state !== m_state) begin n_fail++; $display("FAIL step_model c=%0d: got %h expected %h", c, state, m_state); end
    end
  endtask

  task automatic test_packing();
    logic [W-1:0] ref_w[4];
    ref_w[0] = 8'h00; ref_w[1] = 8'h00; ref_w[2] = 8'h00; ref_w[3] = 8'h40;
    tick(1'b0, 1'b1, 26'h1, 1'b1);
    got_words.delete(); exp_words.delete();
    for (int c = 1; c <= 32; c++) begin
      tick(1'b1, 1'b0, '0, 1'b1);
      n_tests++; if (bus.out_valid !== ((c % W) == 0)) begin n_fail++; $display("FAIL pack_valid c=%0d: got %b expected %b", c, bus.out_valid, ((c % W) == 0)); end
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    n_tests++;
    if (got_words.size() != 4) begin
      n_fail++; $display("FAIL pack_count: got %0d expected 4", got_words.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got_words[i] !== ref_w[i] || got_words[i] !== exp_words[i]) begin
          n_fail++; $display("FAIL pack_word %0d: got %h expected %h", i, got_words[i], ref_w[i]);
        end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] s;
    logic [N-1:0] hold_state;
    logic [W-1:0] hold_word;
    int           edges;
    s = N'($urandom) | 26'h1;
    tick(1'b0, 1'b1, s, 1'b1);
    for (int k = 0; k < 3 * W && !m_valid; k++) tick(1'b1, 1'b0, '0, 1'b1);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 1", bus.out_valid); end
    hold_state = m_state;
    hold_word  = m_word;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b0, '0, 1'b0);
      n_tests++; if (state !== hold_state || m_state !== hold_state) begin n_fail++; $display("FAIL bp_state_frozen: got %h expected %h", state, hold_state); end
      n_tests++; if (bus.out_word !== hold_word || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_word_frozen: got %h/%b expected %h/1", bus.out_word, bus.out_valid, hold_word); end
    end
    edges = 0;
    for (int k = 0; k < 3 * W; k++) begin
      tick(1'b1, 1'b0, '0, 1'b1);
      edges++;
      if (bus.out_valid) break;
    end
    n_tests++; if (edges != W) begin n_fail++; $display("FAIL bp_resume_latency: got %0d expected %0d", edges, W); end
    n_tests++; if (bus.out_word !== m_word) begin n_fail++; $display("FAIL bp_resume_word: got %h expected %h", bus.out_word, m_word); end
  endtask

  task automatic test_zero_seed();
    tick(1'b0, 1'b1, 26'h155, 1'b0);
    for (int k = 0; k < 3 * W && !m_valid; k++) tick(1'b1, 1'b0, '0, 1'b0);
    got_words.delete(); exp_words.delete();
    tick(1'b0, 1'b1, '0, 1'b0);
    n_tests++; if (state !== 26'h1) begin n_fail++; $display("FAIL zero_state: got %h expected 0000001", state); end
    n_tests++; if (zero_fix !== 1'b1) begin n_fail++; $display("FAIL zero_fix_pulse: got %b expected 1", zero_fix); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b expected 0", bus.out_valid); end
    tick(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (zero_fix !== 1'b0) begin n_fail++; $display("FAIL zero_fix_width: got %b expected 0", zero_fix); end
    n_tests++; if (got_words.size() != 0) begin n_fail++; $display("FAIL zero_discard: got %0d words expected 0", got_words.size()); end
  endtask

  task automatic test_load_handshake();
    logic [N-1:0] s;
    s = N'($urandom) | 26'h2;
    for (int k = 0; k < 3 * W && !m_valid; k++) tick(1'b1, 1'b0, '0, 1'b0);
    got_words.delete(); exp_words.delete();
    tick(1'b1, 1'b1, s, 1'b1);
    n_tests++;
    if (got_words.size() != 1 || exp_words.size() != 1) begin
      n_fail++; $display("FAIL ldhs_consumed: got %0d words expected 1", got_words.size());
    end else if (got_words[0] !== exp_words[0]) begin
      n_fail++; $display("FAIL ldhs_word: got %h expected %h", got_words[0], exp_words[0]);
    end
    n_tests++; if (state !== s) begin n_fail++; $display("FAIL ldhs_state: got %h expected %h", state, s); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ldhs_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic         e, l, rd;
    logic [N-1:0] s;
    int           bad;
    got_words.delete(); exp_words.delete();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      e  = ($urandom % 4) != 0;
      l  = ($urandom % 32) == 0;
      s  = (($urandom % 4) == 0) ? '0 : N'($urandom);
      rd = ($urandom % 3) != 0;
      tick(e, l, s, rd);
      n_tests++;
      if (state !== m_state || bus.out_valid !== m_valid || bus.out_word !== m_word || zero_fix !== m_zf) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand c=%0d: got st=%h v=%b w=%h zf=%b expected st=%h v=%b w=%h zf=%b",
                               c, state, bus.out_valid, bus.out_word, zero_fix, m_state, m_valid, m_word, m_zf);
        bad++;
      end
    end
    n_tests++;
    if (got_words.size() != exp_words.size()) begin
      n_fail++; $display("FAIL rand_stream_len: got %0d expected %0d", got_words.size(), exp_words.size());
    end else begin
      foreach (got_words[i])
        if (got_words[i] !== exp_words[i]) begin
          n_fail++; $display("FAIL rand_stream %0d: got %h expected %h", i, got_words[i], exp_words[i]);
          break;
        end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 26'h3A5A5A5, 1'b0);
    for (int k = 0; k < 3 * W && !m_valid; k++) tick(1'b1, 1'b0, '0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", bus.out_valid); end
    #2 r = 1'b0;
    #1;
    n_tests++; if (state !== 26'h1) begin n_fail++; $display("FAIL arst_state: got %h expected 0000001", state); end
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_word !== 8'h00) begin n_fail++; $display("FAIL arst_stream: got %b/%h expected 0/00", bus.out_valid, bus.out_word); end
    @(negedge clk);
    r = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_period();
    load4 = 1'b1; seed4 = 4'h1; en4 = 1'b0;
    @(posedge clk); @(negedge clk);
    load4 = 1'b0; en4 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); @(negedge clk);
      n_tests++; if (state4 === 4'h0) begin n_fail++; $display("FAIL period_zero k=%0d: got %h expected nonzero", k, state4); end
      n_tests++;
      if (k < 15 && state4 === 4'h1) begin n_fail++; $display("FAIL period_early k=%0d: got %h expected not 1", k, state4); end
      else if (k == 15 && state4 !== 4'h1) begin n_fail++; $display("FAIL period_return: got %h expected 1", state4); end
    end
    en4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_step();
    test_packing();
    test_backpressure();
    test_zero_seed();
    test_load_handshake();
    test_random();
    test_async_reset();
    test_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
